// File: rtl/bus_read_capture_pkg.sv
// Shared definitions for the bus read capture block: access size encodings and FSM states.
package bus_read_capture_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/bus_read_capture_load_align.sv
// Combinational lane extraction and sign/zero extension of a fetched 32-bit bus word.
module load_align
  import bus_read_capture_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    unique case (addr)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase

    half_lane = addr[1] ? word[31:16] : word[15:0];

    // The reserved size encoding reads as a full word.
    case (size)
      SZ_BYTE: result = {{24{sext & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{sext & half_lane[15]}}, half_lane};
      SZ_WORD: result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/bus_read_capture.sv
// Single-beat bus read with lane extraction; optional ack timeout under BUS_READ_TIMEOUT_EN.
module bus_read_capture
  import bus_read_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must lie in 2..255");
  end

  state_e      state;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] aligned;

`ifdef BUS_READ_TIMEOUT_EN
  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  load_align u_load_align (
    .word   (bus_din),
    .addr   (addr_lo_q),
    .size   (size_q),
    .sext   (sext_q),
    .result (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      addr_lo_q <= 2'b00;
      size_q    <= 2'b00;
      sext_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_addr  <= 32'h0;
      rdata     <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BUS_READ_TIMEOUT_EN
      wait_cnt_q <= 8'h0;
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BUS_READ_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StReq;
            addr_lo_q <= addr[1:0];
            size_q    <= size;
            sext_q    <= sext;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_req   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StReq: begin
          // Zero-wait memory may ack in the same cycle as the request.
          if (bus_ack) begin
            rdata   <= aligned;
            done    <= 1'b1;
            bus_req <= 1'b0;
            state   <= StDone;
          end else begin
            state <= StWait;
`ifdef BUS_READ_TIMEOUT_EN
            wait_cnt_q <= 8'h0;
`endif
          end
        end
        StWait: begin
          if (bus_ack) begin
            rdata   <= aligned;
            done    <= 1'b1;
            bus_req <= 1'b0;
            state   <= StDone;
          end
`ifdef BUS_READ_TIMEOUT_EN
          else if (wait_cnt_q == LastCnt) begin
            err_q   <= 1'b1;
            bus_req <= 1'b0;
            state   <= StErr;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        StDone, StErr: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_capture.sv
// Randomised scoreboard bench for bus_read_capture; honours BUS_READ_TIMEOUT_EN if defined.
module tb_bus_read_capture;

  localparam int unsigned TimeoutCyc = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sext;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_din;
  logic        bus_ack;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  bit          err_ok = 1'b0;

  always #5 clk = ~clk;

  bus_read_capture #(
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .addr     (addr),
    .size     (size),
    .sext     (sext),
    .bus_req  (bus_req),
    .bus_addr (bus_addr),
    .bus_din  (bus_din),
    .bus_ack  (bus_ack),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the addressed lane by arithmetic, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
    int unsigned shift;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 2'b00) begin
      shift = (a % 4) * 8;
      mask  = 32'hFF;
    end else if (sz == 2'b01) begin
      shift = ((a / 2) % 2) * 16;
      mask  = 32'hFFFF;
    end else begin
      return w;
    end
    v = (w >> shift) & mask;
    if (sx && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
    return v;
  endfunction

  // Monitor: every done pops one expectation; err only allowed while expected.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'h0, done}, 32'h0);
      end else begin
        last_rdata = exp_q.pop_front();
        check("rdata", rdata, last_rdata);
      end
    end
    if (err && !err_ok) check("spurious_err", {31'h0, err}, 32'h0);
  end

  task automatic issue_start(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    @(posedge clk); #1;
    start   = 1'b1;
    addr    = a;
    size    = sz;
    sext    = sx;
    bus_ack = 1'b0;
    bus_din = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    addr  = $urandom;
    check("req_strobe", {31'h0, bus_req}, 32'h1);
    check("req_addr", bus_addr, a & ~32'h3);
  endtask

  // waits = number of cycles after the REQ cycle before ack is presented.
  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         input logic [31:0] din, input int unsigned waits, input bit noise);
    issue_start(a, sz, sx);
    exp_q.push_back(ref_load(din, a, sz, sx));
    for (int w = 0; w < int'(waits); w++) begin
      bus_ack = 1'b0;
      bus_din = $urandom;
      start   = noise;
      @(posedge clk); #1;
      check("wait_strobe", {31'h0, bus_req}, 32'h1);
      check("wait_addr", bus_addr, a & ~32'h3);
    end
    start   = 1'b0;
    bus_ack = 1'b1;
    bus_din = din;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    bus_din = $urandom;
    check("done_latency", {31'h0, done}, 32'h1);
    start = noise;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("idle_req", {31'h0, bus_req}, 32'h0);
    bus_ack = 1'($urandom);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("stray_ack_req", {31'h0, bus_req}, 32'h0);
    check("stray_ack_done", {31'h0, done}, 32'h0);
  endtask

  initial begin
    int c;
    reset   = 1'b1;
    start   = 1'b0;
    addr    = 32'h0;
    size    = 2'b00;
    sext    = 1'b0;
    bus_din = 32'h0;
    bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'h0, bus_req}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    reset = 1'b0;

    do_read(32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 1, 1'b0);
    do_read(32'h103, 2'b00, 1'b1, 32'h80FF00AA, 0, 1'b0);
    do_read(32'h202, 2'b01, 1'b0, 32'h9ABC1234, 1, 1'b0);
    do_read(32'h201, 2'b01, 1'b1, 32'h1234F00D, 2, 1'b1);
    do_read(32'h300, 2'b11, 1'b1, 32'h87654321, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
`ifdef BUS_READ_TIMEOUT_EN
      do_read($urandom, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
              1'($urandom));
`else
      do_read($urandom, 2'($urandom), 1'($urandom), $urandom, $urandom_range(0, 6),
              1'($urandom));
`endif
    end

`ifdef BUS_READ_TIMEOUT_EN
    issue_start(32'h400, 2'b10, 1'b0);
    err_ok = 1'b1;
    c = 0;
    while (!err && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("timeout_cycle", c, 32'd5);
    check("timeout_err", {31'h0, err}, 32'h1);
    check("timeout_req", {31'h0, bus_req}, 32'h0);
    check("timeout_rdata", rdata, last_rdata);
    @(posedge clk); #1;
    err_ok = 1'b0;
    check("timeout_err_once", {31'h0, err}, 32'h0);
    check("timeout_busy", {31'h0, busy}, 32'h0);
    check("timeout_rdata_hold", rdata, last_rdata);
`else
    issue_start(32'h400, 2'b10, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check("no_timeout_busy", {31'h0, busy}, 32'h1);
    check("no_timeout_req", {31'h0, bus_req}, 32'h1);
    check("no_timeout_err", {31'h0, err}, 32'h0);
    exp_q.push_back(32'h0BADF00D);
    bus_ack = 1'b1;
    bus_din = 32'h0BADF00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("late_done", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
`endif

    // Abort in WAIT with reset, then a late ack must be ignored.
    issue_start(32'h504, 2'b10, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    bus_ack = 1'b1;
    bus_din = 32'h55AA55AA;
    check("abort_req", {31'h0, bus_req}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    last_rdata = 32'h0;
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);
    check("abort_idle_req", {31'h0, bus_req}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", {31'h0, busy}, 32'h0);

    do_read(32'h602, 2'b00, 1'b1, 32'h00C30000, 0, 1'b0);
    check("sb_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not terminate");
  end

endmodule
